pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined successor to the single-cycle decoder for the 5-stage MIPS core.
//  - Decodes op/func in ID and carries control through ID/EX, EX/MEM and MEM/WB registers.
//  - Resolves beq/bne in EX.
//  - Generates stall, flush and (optionally) forwarding selects.
//  - All datapath enables and muxes are driven from here.
// PARAMETERS
//  RADDR_W  5  register-address width (register file depth = 2**RADDR_W)
//  ALUOP_W  3  ALU opcode width; codes are zero-extended into it (must be >= 3)
//  ZERO_REG 0  index of the hardwired-zero register; never a hazard source
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous active-low reset
//  id_op       in   6        opcode of the instruction in ID
//  id_func     in   6        funct field of the instruction in ID
//  id_rs       in   RADDR_W  rs field in ID
//  id_rt       in   RADDR_W  rt field in ID
//  id_rd       in   RADDR_W  rd field in ID
//  ex_zero     in   1        ALU zero flag of the instruction in EX
//  pc_en       out  1        PC load enable (0 = hold)
//  ifid_en     out  1        IF/ID register load enable
//  flush_ifid  out  1        clear IF/ID to nop next edge
//  pc_src      out  1        1 = load branch target
//  id_sgnzero  out  1        1 = sign-extend imm, 0 = zero-extend
//  id_illegal  out  1        unknown opcode/funct in ID (pulse per decode)
//  ex_alu_op   out  ALUOP_W  ALU op for EX
//  ex_alu_src  out  1        1 = immediate operand B
//  ex_wreg     out  RADDR_W  destination register of EX instruction (rd or rt)
//  mem_write   out  1        data-memory write enable
//  wb_regwrite out  1        register-file write enable
//  wb_mem2reg  out  1        1 = write-back from memory
//  wb_wreg     out  RADDR_W  write-back destination
//  fwd_a       out  2        operand-A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  fwd_b       out  2        operand-B select: same encoding as fwd_a
// BEHAVIOUR
//  - Decode table (ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu):
//    - op 0 R-type: func 32–43 as MIPS. func 0 = nop (no writes).
//    - Any other R-type func: bubble, id_illegal=1.
//    - Immediates: addi/addiu sign-extend; andi/ori/xori zero-extend; slti/sltiu sign-extend.
//    - Memory: lw 35, sw 43.
//    - Branches: beq 4, bne 5 (sub, sign-extend).
//    - Any other op: bubble, id_illegal=1.
//  - Dest = rd for R-type, rt for I-type. A write to ZERO_REG is suppressed (regwrite forced 0).
//  - Operand use: rs read by all non-nop instructions; rt read by R-type, beq, bne, sw.
//  - Stage regs advance every clk; a bubble means all write/branch bits = 0.
//  - Branch: pc_src = ex_branch & (ex_zero ^ ex_is_bne), combinational from EX.
//    - When pc_src=1: flush_ifid=1 and ID/EX loads a bubble at the next edge.
//    - Branch flush takes priority over stall: pc_en=1, ifid_en=1.
//  - Stall (stall=1): pc_en=0, ifid_en=0, ID/EX loads a bubble; EX/MEM and MEM/WB advance.
//  - Hazard match = writer's regwrite=1, dest==source, source!=ZERO_REG, source actually used.
//  - WB writes first half-cycle; WB-stage matches never stall.
//  - Reset (rst_n=0 at an edge, including mid-stall/mid-branch):
//    - all stage regs become bubbles, fwd_*=00;
//    - pc_en=1, ifid_en=1, pc_src=0, flush_ifid=0, id_illegal follows ID inputs.
//  - Throughput 1 instr/clk absent hazards; decode->WB latency 3 clk after ID.
// CONFIGURATION
//  - FORWARD_EN defined:
//    - stall only on load-use (EX is lw with matching dest); exactly 1 cycle per lw.
//    - fwd_x = 01 if EX/MEM matches the EX source; else 10 if MEM/WB matches; else 00. EX/MEM has priority.
//  - FORWARD_EN undefined:
//    - fwd_a = fwd_b = 00 constant.
//    - Stall while any ID source matches an EX or MEM writer: up to 2 cycles.
// TESTING
//  - Reset: hold rst_n=0 2 clk with random inputs -> all writes 0, pc_en=1, pc_src=0, fwd 00.
//  - Sequence add $3,$1,$2; sub $4,$3,$1:
//    - FORWARD_EN: no stall, fwd_a=01 at sub in EX.
//    - No FORWARD_EN: 2 stall cycles.
//  - lw $5,0($1); add $6,$5,$5:
//    - FORWARD_EN: exactly 1 stall, then fwd_a=fwd_b=10.
//    - No FORWARD_EN: 2 stalls.
//  - beq $1,$1 with ex_zero=1: pc_src=1, flush_ifid=1, next EX bubble.
//    - Same case with ex_zero=0: no flush.
//    - bne with ex_zero=0: pc_src=1.
//  - Load-use stall coinciding with a taken branch in EX: pc_en=1, flush wins, no stall cycle.
//  - addi $0,$1,5 then add $2,$0,$0 -> wb_regwrite=0, no stall, fwd 00.
//    - op 63 -> id_illegal=1, bubble.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control path for the 5-stage MIPS pipeline.
// Decodes op/func in ID, carries control through ID/EX, EX/MEM and MEM/WB,
// resolves beq/bne in EX and produces stall, flush and forwarding selects.
// Optional feature macro: FORWARD_EN (forwarding selects; stall only on load-use).
module pipe_ctrl_unit #(
  parameter int unsigned RaddrW  = 5,
  parameter int unsigned AluOpW  = 3,
  parameter int unsigned ZeroReg = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [5:0]        id_op_i,
  input  logic [5:0]        id_func_i,
  input  logic [RaddrW-1:0] id_rs_i,
  input  logic [RaddrW-1:0] id_rt_i,
  input  logic [RaddrW-1:0] id_rd_i,
  input  logic              ex_zero_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              flush_ifid_o,
  output logic              pc_src_o,
  output logic              id_sgnzero_o,
  output logic              id_illegal_o,
  output logic [AluOpW-1:0] ex_alu_op_o,
  output logic              ex_alu_src_o,
  output logic [RaddrW-1:0] ex_wreg_o,
  output logic              mem_write_o,
  output logic              wb_regwrite_o,
  output logic              wb_mem2reg_o,
  output logic [RaddrW-1:0] wb_wreg_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  localparam logic [RaddrW-1:0] ZeroAddr = RaddrW'(ZeroReg);

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluAnd  = 3'd2;
  localparam logic [2:0] AluOr   = 3'd3;
  localparam logic [2:0] AluXor  = 3'd4;
  localparam logic [2:0] AluNor  = 3'd5;
  localparam logic [2:0] AluSlt  = 3'd6;
  localparam logic [2:0] AluSltu = 3'd7;

  // An all-zero struct is a bubble: no write and no branch bits set.
  typedef struct packed {
    logic [AluOpW-1:0] alu_op;
    logic              alu_src;
    logic [RaddrW-1:0] wreg;
    logic              regwrite;
    logic              mem2reg;
    logic              mem_write;
    logic              branch;
    logic              is_bne;
`ifdef FORWARD_EN
    logic [RaddrW-1:0] rs;
    logic [RaddrW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
`endif
  } idex_t;

  typedef struct packed {
    logic              regwrite;
    logic              mem2reg;
    logic              mem_write;
    logic [RaddrW-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic              regwrite;
    logic              mem2reg;
    logic [RaddrW-1:0] wreg;
  } memwb_t;

  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   id_use_rs, id_use_rt, r_ok;
  logic   [2:0] alu_code;
  logic   stall;

  function automatic logic hz_match(input logic              rw,
                                    input logic [RaddrW-1:0] wreg,
                                    input logic [RaddrW-1:0] src,
                                    input logic              used);
    return rw & used & (src != ZeroAddr) & (wreg == src);
  endfunction

  // ID decode: control word for the instruction currently in ID.
  always_comb begin
    dec          = '0;
    alu_code     = AluAdd;
    r_ok         = 1'b0;
    id_use_rs    = 1'b0;
    id_use_rt    = 1'b0;
    id_sgnzero_o = 1'b0;
    id_illegal_o = 1'b0;
    case (id_op_i)
      6'd0: begin
        case (id_func_i)
          6'd0:         r_ok = 1'b0;  // nop: reads and writes nothing
          6'd32, 6'd33: begin r_ok = 1'b1; alu_code = AluAdd;  end
          6'd34, 6'd35: begin r_ok = 1'b1; alu_code = AluSub;  end
          6'd36:        begin r_ok = 1'b1; alu_code = AluAnd;  end
          6'd37:        begin r_ok = 1'b1; alu_code = AluOr;   end
          6'd38:        begin r_ok = 1'b1; alu_code = AluXor;  end
          6'd39:        begin r_ok = 1'b1; alu_code = AluNor;  end
          6'd42:        begin r_ok = 1'b1; alu_code = AluSlt;  end
          6'd43:        begin r_ok = 1'b1; alu_code = AluSltu; end
          default:      id_illegal_o = 1'b1;
        endcase
        if (r_ok) begin
          dec.regwrite = 1'b1;
          dec.wreg     = id_rd_i;
          id_use_rs    = 1'b1;
          id_use_rt    = 1'b1;
        end
      end
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd35: begin
        dec.regwrite = 1'b1;
        dec.alu_src  = 1'b1;
        dec.wreg     = id_rt_i;
        dec.mem2reg  = (id_op_i == 6'd35);
        id_use_rs    = 1'b1;
        id_sgnzero_o = (id_op_i < 6'd12) || (id_op_i == 6'd35);
        case (id_op_i)
          6'd10:   alu_code = AluSlt;
          6'd11:   alu_code = AluSltu;
          6'd12:   alu_code = AluAnd;
          6'd13:   alu_code = AluOr;
          6'd14:   alu_code = AluXor;
          default: alu_code = AluAdd;
        endcase
      end
      6'd43: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        id_use_rs     = 1'b1;
        id_use_rt     = 1'b1;
        id_sgnzero_o  = 1'b1;
      end
      6'd4, 6'd5: begin
        dec.branch   = 1'b1;
        dec.is_bne   = (id_op_i == 6'd5);
        alu_code     = AluSub;
        id_use_rs    = 1'b1;
        id_use_rt    = 1'b1;
        id_sgnzero_o = 1'b1;
      end
      default: id_illegal_o = 1'b1;
    endcase
    if (dec.wreg == ZeroAddr) dec.regwrite = 1'b0;
    dec.alu_op = AluOpW'(alu_code);
`ifdef FORWARD_EN
    dec.rs     = id_rs_i;
    dec.rt     = id_rt_i;
    dec.use_rs = id_use_rs;
    dec.use_rt = id_use_rt;
`endif
  end

  // Hazard detection, branch resolution and next-state of the stage registers.
  always_comb begin
`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded in time.
    stall = idex_q.regwrite & idex_q.mem2reg &
            (hz_match(idex_q.regwrite, idex_q.wreg, id_rs_i, id_use_rs) |
             hz_match(idex_q.regwrite, idex_q.wreg, id_rt_i, id_use_rt));
`else
    // WB writes in the first half-cycle, so only EX and MEM writers stall.
    stall = hz_match(idex_q.regwrite, idex_q.wreg, id_rs_i, id_use_rs) |
            hz_match(idex_q.regwrite, idex_q.wreg, id_rt_i, id_use_rt) |
            hz_match(exmem_q.regwrite, exmem_q.wreg, id_rs_i, id_use_rs) |
            hz_match(exmem_q.regwrite, exmem_q.wreg, id_rt_i, id_use_rt);
`endif
    pc_src_o     = idex_q.branch & (ex_zero_i ^ idex_q.is_bne);
    flush_ifid_o = pc_src_o;
    // A taken branch discards the stalled instruction, so the stall is moot.
    pc_en_o      = ~stall | pc_src_o;
    ifid_en_o    = ~stall | pc_src_o;
    idex_d       = (stall | pc_src_o) ? idex_t'('0) : dec;

    exmem_d           = '0;
    exmem_d.regwrite  = idex_q.regwrite;
    exmem_d.mem2reg   = idex_q.mem2reg;
    exmem_d.mem_write = idex_q.mem_write;
    exmem_d.wreg      = idex_q.wreg;

    memwb_d          = '0;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.mem2reg  = exmem_q.mem2reg;
    memwb_d.wreg     = exmem_q.wreg;
  end

  // Stage registers; synchronous reset turns every stage into a bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

`ifdef FORWARD_EN
  // Forwarding selects for the EX operands; the younger EX/MEM result wins.
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (hz_match(exmem_q.regwrite, exmem_q.wreg, idex_q.rs, idex_q.use_rs)) begin
      fwd_a_o = 2'b01;
    end else if (hz_match(memwb_q.regwrite, memwb_q.wreg, idex_q.rs, idex_q.use_rs)) begin
      fwd_a_o = 2'b10;
    end
    if (hz_match(exmem_q.regwrite, exmem_q.wreg, idex_q.rt, idex_q.use_rt)) begin
      fwd_b_o = 2'b01;
    end else if (hz_match(memwb_q.regwrite, memwb_q.wreg, idex_q.rt, idex_q.use_rt)) begin
      fwd_b_o = 2'b10;
    end
  end
`else
  assign fwd_a_o = 2'b00;
  assign fwd_b_o = 2'b00;
`endif

  assign ex_alu_op_o   = idex_q.alu_op;
  assign ex_alu_src_o  = idex_q.alu_src;
  assign ex_wreg_o     = idex_q.wreg;
  assign mem_write_o   = exmem_q.mem_write;
  assign wb_regwrite_o = memwb_q.regwrite;
  assign wb_mem2reg_o  = memwb_q.mem2reg;
  assign wb_wreg_o     = memwb_q.wreg;

endmodule
